// File: rtl/max_pool_pkg.sv
// Shared sizing helpers for the max-pooling reduction tree.
package max_pool_pkg;

  // Number of registered comparator levels: ceil(log2(pool)), never fewer than one.
  function automatic int pool_levels(input int pool);
    return (pool <= 2) ? 1 : $clog2(pool);
  endfunction

  // Leaf count after padding the window up to a full binary tree.
  function automatic int pool_leaves(input int pool);
    return 1 << pool_levels(pool);
  endfunction

endpackage

// File: rtl/max_pool_reduce_max2_cell.sv
// Combinational two-input unsigned maximum; one per comparator tree node.
module max2_cell #(
  parameter int W = 20
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  assign y_o = (a_i >= b_i) ? a_i : b_i;

endmodule

// File: rtl/max_pool_reduce.sv
// Fully pipelined max over a POOL_-element window; one window per clock, latency = tree depth.
module max_pool_reduce
  import max_pool_pkg::*;
#(
  parameter int input_width  = 20,
  parameter int output_width = 20,
  parameter int POOL_        = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [input_width-1:0]  ifm_input [POOL_],
  output logic [output_width-1:0] ifm_output
);

  localparam int LEVELS = pool_levels(POOL_);
  localparam int LEAVES = pool_leaves(POOL_);

  if (output_width < input_width) begin : g_bad_width
    $error("max_pool_reduce: output_width must be >= input_width");
  end
  if (POOL_ < 1) begin : g_bad_pool
    $error("max_pool_reduce: POOL_ must be >= 1");
  end

  // Missing leaves read as 0, which can never win an unsigned max.
  logic [input_width-1:0] leaf [LEAVES];

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < POOL_) begin : g_real
      assign leaf[i] = ifm_input[i];
    end else begin : g_pad
      assign leaf[i] = '0;
    end
  end

  // Heap-numbered tree: node 1 is the root, node i has children 2i and 2i+1.
  // Every internal node is a register, so each tree level is one pipeline stage.
  logic [input_width-1:0] node_d [1:LEAVES-1];
  logic [input_width-1:0] node_q [1:LEAVES-1];

  for (genvar n = 1; n < LEAVES; n++) begin : g_node
    if (2 * n >= LEAVES) begin : g_from_leaf
      max2_cell #(.W(input_width)) u_max (
        .a_i (leaf[2*n-LEAVES]),
        .b_i (leaf[2*n+1-LEAVES]),
        .y_o (node_d[n])
      );
    end else begin : g_from_node
      max2_cell #(.W(input_width)) u_max (
        .a_i (node_q[2*n]),
        .b_i (node_q[2*n+1]),
        .y_o (node_d[n])
      );
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int n = 1; n < LEAVES; n++) begin
        node_q[n] <= '0;
      end
    end else begin
      for (int n = 1; n < LEAVES; n++) begin
        node_q[n] <= node_d[n];
      end
    end
  end

  always_comb begin
    ifm_output = '0;
    ifm_output[input_width-1:0] = node_q[1];
  end

endmodule

// File: tb/tb_max_pool_reduce.sv
// Randomized bench for max_pool_reduce across four configurations against a history-queue model.
module tb_max_pool_reduce;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [19:0] in_a  [4];
  logic [19:0] in_p3 [3];
  logic [19:0] in_p1 [1];
  logic [7:0]  in_w  [4];
  logic [19:0] out_a, out_p3, out_p1;
  logic [11:0] out_w;

  max_pool_reduce #(.input_width(20), .output_width(20), .POOL_(4)) dut_a (
    .clk(clk), .rst_n(rst), .ifm_input(in_a), .ifm_output(out_a));
  max_pool_reduce #(.input_width(20), .output_width(20), .POOL_(3)) dut_p3 (
    .clk(clk), .rst_n(rst), .ifm_input(in_p3), .ifm_output(out_p3));
  max_pool_reduce #(.input_width(20), .output_width(20), .POOL_(1)) dut_p1 (
    .clk(clk), .rst_n(rst), .ifm_input(in_p1), .ifm_output(out_p1));
  max_pool_reduce #(.input_width(8), .output_width(12), .POOL_(4)) dut_w (
    .clk(clk), .rst_n(rst), .ifm_input(in_w), .ifm_output(out_w));

  // Expected latencies: ceil(log2(POOL_)) with a floor of 1.
  localparam int LAT_A  = 2;
  localparam int LAT_P3 = 2;
  localparam int LAT_P1 = 1;
  localparam int LAT_W  = 2;

  // Window maxima in the order they were accepted since the last reset.
  logic [31:0] exp_q_a[$], exp_q_p3[$], exp_q_p1[$], exp_q_w[$];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] expected(input logic [31:0] q[$], input int lat);
    if (q.size() < lat) return 32'd0;
    return q[q.size() - lat];
  endfunction

  task automatic clear_model();
    exp_q_a.delete();
    exp_q_p3.delete();
    exp_q_p1.delete();
    exp_q_w.delete();
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, "_p4"}, 32'(out_a),  expected(exp_q_a,  LAT_A));
    check_eq({tag, "_p3"}, 32'(out_p3), expected(exp_q_p3, LAT_P3));
    check_eq({tag, "_p1"}, 32'(out_p1), expected(exp_q_p1, LAT_P1));
    check_eq({tag, "_w"},  32'(out_w),  expected(exp_q_w,  LAT_W));
  endtask

  // One clock: record accepted windows at the edge, compare on the falling edge.
  task automatic tick(input string tag);
    logic [31:0] m;
    @(posedge clk);
    if (rst) begin
      clear_model();
    end else begin
      m = 0; foreach (in_a[i])  if (32'(in_a[i])  > m) m = 32'(in_a[i]);  exp_q_a.push_back(m);
      m = 0; foreach (in_p3[i]) if (32'(in_p3[i]) > m) m = 32'(in_p3[i]); exp_q_p3.push_back(m);
      m = 0; foreach (in_p1[i]) if (32'(in_p1[i]) > m) m = 32'(in_p1[i]); exp_q_p1.push_back(m);
      m = 0; foreach (in_w[i])  if (32'(in_w[i])  > m) m = 32'(in_w[i]);  exp_q_w.push_back(m);
    end
    @(negedge clk);
    check_all(tag);
  endtask

  function automatic logic [19:0] rand20();
    return ($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'($urandom);
  endfunction

  task automatic drive_random();
    foreach (in_a[i])  in_a[i]  = rand20();
    foreach (in_p3[i]) in_p3[i] = rand20();
    foreach (in_p1[i]) in_p1[i] = rand20();
    foreach (in_w[i])  in_w[i]  = 8'($urandom);
  endtask

  task automatic drive_a(input logic [19:0] v0, input logic [19:0] v1,
                         input logic [19:0] v2, input logic [19:0] v3);
    in_a[0] = v0; in_a[1] = v1; in_a[2] = v2; in_a[3] = v3;
  endtask

  task automatic async_reset_pulse(input string tag);
    rst = 1'b1;
    #1;
    clear_model();
    check_all(tag);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    drive_random();
    // Asynchronous clear before any clock edge has occurred.
    #1;
    async_reset_pulse("por");
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive_random();
      tick("rst_hold");
    end

    rst = 1'b0;
    drive_random();
    drive_a(20'd5, 20'd17, 20'd3, 20'd9);
    in_w[0] = 8'h80; in_w[1] = 8'hFF; in_w[2] = 8'h01; in_w[3] = 8'h7F;
    tick("basic");
    drive_random();
    drive_a(20'hFFFFF, 20'd0, 20'd0, 20'd0);
    tick("basic");
    check_eq("basic_17", 32'(out_a), 32'd17);
    check_eq("wext_0ff", 32'(out_w), 32'h0FF);
    drive_random();
    drive_a(20'd0, 20'd0, 20'd0, 20'd1);
    tick("extreme");
    check_eq("top_fffff", 32'(out_a), 32'hFFFFF);
    drive_random();
    drive_a(20'd7, 20'd7, 20'd7, 20'd7);
    tick("extreme");
    check_eq("last_1", 32'(out_a), 32'd1);
    drive_random();
    tick("extreme");
    check_eq("equal_7", 32'(out_a), 32'd7);

    for (int c = 0; c < 1000; c++) begin
      drive_random();
      tick("stream");
    end

    // Mid-stream pulse between edges: in-flight windows must be discarded.
    async_reset_pulse("mid_rst");
    drive_random();
    drive_a(20'd3, 20'd11, 20'd2, 20'd4);
    tick("refill");
    check_eq("refill_zero", 32'(out_a), 32'd0);
    drive_random();
    tick("refill");
    check_eq("refill_11", 32'(out_a), 32'd11);
    for (int c = 0; c < 40; c++) begin
      drive_random();
      tick("post_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_pool_reduce.md
Name: max_pool_reduce

Overview:
- Pipelined max-reduction unit for the CNN accelerator's pooling stage.
- Each cycle it takes one pooling window of POOL_ unsigned feature-map values, presented in parallel.
- It outputs the largest value after a fixed latency.
- Sits downstream of the conv/activation path; no handshake, so the stream is always valid and one window is accepted per clock.

Parameters:
- input_width, 20, bit width of each unsigned input element.
- output_width, 20, bit width of result; must be >= input_width.
- POOL_, 4, number of elements per pooling window; must be >= 1.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst_n  input  1  reset; asynchronous and active-high (asserted at 1), port name kept per codebase convention.
- ifm_input  input  [input_width-1:0] x POOL_ (unpacked array, index 0..POOL_-1)  window elements.
- ifm_output  output  output_width  maximum of the window, registered.

Behaviour:
- One clock; reset is asynchronous and active-high.
- While rst_n=1, every pipeline register and ifm_output clear to 0 immediately, with no clock edge needed. After deassertion, normal operation resumes on the next rising edge.
- Comparison is unsigned magnitude.
- Ties select either operand; the value is identical.
- Balanced binary comparator tree with L = max(1, clog2(POOL_)) levels. Every level is registered.
- Latency is L cycles, so POOL_=4 gives 2 cycles.
- Throughput is one window per cycle, fully pipelined.
- Non-power-of-2 POOL_: the tree is padded to 2^L leaves with 0, the identity for unsigned max.
- POOL_=1: the single element is registered once, latency 1.
- Result is zero-extended from input_width to output_width.
- output_width < input_width is illegal; a generate-time $error fires.
- ifm_output after deassertion: holds 0 until the first window sampled after reset has traversed L stages. It then shows max(window sampled L cycles earlier).
- Reset asserted mid-stream: all in-flight windows are discarded, and the output shows 0 until refilled.
- Inputs containing X are not masked; they propagate.

Decomposition:
- Package max_pool_pkg holds:
  - the localparam/function for L (clog2 with a floor of 1);
  - the padded leaf count 2^L.
- One natural sub-module: max2_cell, a combinational 2-input unsigned max parameterised on width. It is instantiated per tree node via generate.
- The level registers live in the parent.

Test Plan:
- Reset: hold rst_n=1 with random inputs -> ifm_output stays 0 on every edge. Assert rst_n asynchronously mid-cycle -> output goes 0 before the next edge.
- Basic max: after deassertion, apply {5, 17, 3, 9} -> ifm_output = 17 exactly 2 cycles later. Before that it shows 0.
- Position/extremes, back-to-back one per cycle:
  - {20'hFFFFF, 0, 0, 0} -> 20'hFFFFF.
  - {0, 0, 0, 1} -> 1.
  - all-equal {7, 7, 7, 7} -> 7.
  - Each appears in order, 2 cycles after application, with no bubbles.
- Streaming random: 1000 cycles of random windows -> each output matches the model max delayed by L. Also run with POOL_=3 (padding) and POOL_=1 (latency 1).
- Width extension: input_width=8, output_width=12, window {8'h80, 8'hFF, 8'h01, 8'h7F} -> 12'h0FF.
- Mid-stream reset: stream windows, pulse rst_n high for 3 ns between edges -> output 0 immediately. The first post-reset window appears after L cycles; earlier windows never reappear.
